// File: rtl/vrams_pkg.sv
// Shared VRAMS constants and types, also used by the VRAMS storage and the VGA scanout.
package vrams_pkg;

    localparam int VRAMS_DEPTH  = 48;
    localparam int VRAMS_ADDR_W = 9;
    localparam int VRAMS_DATA_W = 16;
    localparam int VRAMS_FCNT_W = 6;

    typedef enum logic {
        IDLE,
        FILL
    } fill_state_t;

endpackage

// File: rtl/vrams_hold_buf.sv
// One-entry CPU write holding buffer with stall, plus the out-of-range check and
// saturating drop counter.
module vrams_hold_buf
    import vrams_pkg::*;
#(
    parameter int DEPTH  = VRAMS_DEPTH,
    parameter int ADDR_W = VRAMS_ADDR_W,
    parameter int DATA_W = VRAMS_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ok,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_busy,
    output logic              hb_valid,
    output logic [ADDR_W-1:0] hb_addr,
    output logic [DATA_W-1:0] hb_data,
    output logic [7:0]        drop_cnt
);

    logic accept;
    logic in_range;
    logic hb_issue;

    // The buffer drains whenever ok, so it can refill in the same cycle it issues.
    assign hb_issue = hb_valid & ok;
    assign cpu_busy = hb_valid & ~ok;
    assign accept   = cpu_we & ~cpu_busy;
    assign in_range = cpu_addr < ADDR_W'(DEPTH);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hb_valid <= 1'b0;
            hb_addr  <= '0;
            hb_data  <= '0;
            drop_cnt <= '0;
        end else begin
            if (accept && in_range) begin
                hb_valid <= 1'b1;
                hb_addr  <= cpu_addr;
                hb_data  <= cpu_data;
            end else if (hb_issue) begin
                hb_valid <= 1'b0;
            end
            if (accept && !in_range && drop_cnt != 8'hFF) begin
                drop_cnt <= drop_cnt + 8'd1;
            end
        end
    end

endmodule

// File: rtl/vrams_write_scheduler.sv
// Merges CPU writes and the hardware fill engine onto the single VRAMS write port,
// optionally gating commits to display blanking.
module vrams_write_scheduler
    import vrams_pkg::*;
#(
    parameter int DEPTH      = VRAMS_DEPTH,
    parameter int ADDR_W     = VRAMS_ADDR_W,
    parameter int DATA_W     = VRAMS_DATA_W,
    parameter int BLANK_SYNC = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_data,
    output logic              cpu_busy,
    input  logic              fill_start,
    input  logic [DATA_W-1:0] fill_value,
    output logic              fill_busy,
    output logic              fill_done,
    input  logic              blank,
    output logic [7:0]        drop_cnt,
    output logic              vram_we,
    output logic [ADDR_W-1:0] vram_addr,
    output logic [DATA_W-1:0] vram_data
);

    logic                    ok;
    logic                    hb_valid;
    logic [ADDR_W-1:0]       hb_addr;
    logic [DATA_W-1:0]       hb_data;
    logic                    cpu_issue;
    logic                    fill_issue;
    logic                    last_cell;
    fill_state_t             state, state_nx;
    logic [VRAMS_FCNT_W-1:0] fcnt, fcnt_nx;
    logic [DATA_W-1:0]       fill_val, fill_val_nx;
    logic                    done_nx;

    assign ok = (BLANK_SYNC == 0) || blank;

    vrams_hold_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_hold_buf (
        .clk      (clk),
        .rst      (rst),
        .ok       (ok),
        .cpu_we   (cpu_we),
        .cpu_addr (cpu_addr),
        .cpu_data (cpu_data),
        .cpu_busy (cpu_busy),
        .hb_valid (hb_valid),
        .hb_addr  (hb_addr),
        .hb_data  (hb_data),
        .drop_cnt (drop_cnt)
    );

    // CPU buffer has priority; the fill simply stalls a cycle on collision.
    assign cpu_issue  = hb_valid & ok;
    assign fill_issue = (state == FILL) & ok & ~cpu_issue;
    assign last_cell  = fcnt == VRAMS_FCNT_W'(DEPTH - 1);
    assign fill_busy  = (state == FILL);

    always_comb begin
        state_nx    = state;
        fcnt_nx     = fcnt;
        fill_val_nx = fill_val;
        done_nx     = 1'b0;
        case (state)
            IDLE: begin
                if (fill_start) begin
                    fill_val_nx = fill_value;
                    fcnt_nx     = '0;
                    state_nx    = FILL;
                end
            end
            FILL: begin
                if (fill_issue) begin
                    if (last_cell) begin
                        state_nx = IDLE;
                        done_nx  = 1'b1;
                    end else begin
                        fcnt_nx = fcnt + 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            fcnt      <= '0;
            fill_val  <= '0;
            fill_done <= 1'b0;
        end else begin
            state     <= state_nx;
            fcnt      <= fcnt_nx;
            fill_val  <= fill_val_nx;
            fill_done <= done_nx;
        end
    end

    // Address and data hold their last value between writes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vram_we   <= 1'b0;
            vram_addr <= '0;
            vram_data <= '0;
        end else begin
            vram_we <= cpu_issue | fill_issue;
            if (cpu_issue) begin
                vram_addr <= hb_addr;
                vram_data <= hb_data;
            end else if (fill_issue) begin
                vram_addr <= {{(ADDR_W - VRAMS_FCNT_W){1'b0}}, fcnt};
                vram_data <= fill_val;
            end
        end
    end

endmodule

// File: tb/tb_vrams_write_scheduler.sv
// Self-checking bench for vrams_write_scheduler (BLANK_SYNC=1): directed scenarios plus a
// randomized CPU/blank run checked against an ordered-write reference model.
module tb_vrams_write_scheduler;

    localparam int DEPTH  = 48;
    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              cpu_we = 1'b0;
    logic [ADDR_W-1:0] cpu_addr = '0;
    logic [DATA_W-1:0] cpu_data = '0;
    logic              cpu_busy;
    logic              fill_start = 1'b0;
    logic [DATA_W-1:0] fill_value = '0;
    logic              fill_busy;
    logic              fill_done;
    logic              blank = 1'b0;
    logic [7:0]        drop_cnt;
    logic              vram_we;
    logic [ADDR_W-1:0] vram_addr;
    logic [DATA_W-1:0] vram_data;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cyc;
    } wr_t;

    wr_t  wr_q[$];
    int   done_q[$];
    logic done_busy_q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_blank = 1'b0;
    int   gate_err = 0;
    logic busy_seen = 1'b0;

    always #5 clk = ~clk;

    vrams_write_scheduler #(
        .DEPTH      (DEPTH),
        .ADDR_W     (ADDR_W),
        .DATA_W     (DATA_W),
        .BLANK_SYNC (1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_data   (cpu_data),
        .cpu_busy   (cpu_busy),
        .fill_start (fill_start),
        .fill_value (fill_value),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .blank      (blank),
        .drop_cnt   (drop_cnt),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_data  (vram_data)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Observe the write port mid-cycle; prev_blank is the blank level of the issue cycle.
    always @(negedge clk) begin
        if (vram_we === 1'b1) begin
            if (prev_blank !== 1'b1) gate_err++;
            wr_q.push_back('{vram_addr, vram_data, cyc});
        end
        if (fill_done === 1'b1) begin
            done_q.push_back(cyc);
            done_busy_q.push_back(fill_busy);
        end
        if (cpu_busy === 1'b1) busy_seen = 1'b1;
        prev_blank = blank;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog");
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic clear_obs();
        wr_q.delete();
        done_q.delete();
        done_busy_q.delete();
        gate_err  = 0;
        busy_seen = 1'b0;
    endtask

    // Holds the request until the DUT accepts it; acc_cyc is the accepting edge number.
    task automatic cpu_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d,
                             output int acc_cyc);
        acc_cyc  = -1;
        cpu_addr = a;
        cpu_data = d;
        cpu_we   = 1'b1;
        for (int i = 0; i < 50; i++) begin
            #1;
            if (cpu_busy === 1'b0) begin
                @(posedge clk);
                #1;
                acc_cyc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        cpu_we = 1'b0;
        checks++;
        if (acc_cyc < 0) begin
            failures++;
            $display("[TB] FAIL cpu_accept_timeout addr=%0d got=not_accepted exp=accepted", a);
        end
    endtask

    task automatic pulse_fill(input logic [DATA_W-1:0] v);
        fill_value = v;
        fill_start = 1'b1;
        @(posedge clk);
        #1;
        fill_start = 1'b0;
        fill_value = ~v;
    endtask

    task automatic wait_fill_done();
        for (int i = 0; i < 200 && done_q.size() == 0; i++) step(1);
        step(3);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        step(3);
        checks++; if (vram_we !== 1'b0) begin failures++; $display("[TB] FAIL reset_vram_we got=%0b exp=0", vram_we); end
        checks++; if (vram_addr !== '0) begin failures++; $display("[TB] FAIL reset_vram_addr got=%0h exp=0", vram_addr); end
        checks++; if (vram_data !== '0) begin failures++; $display("[TB] FAIL reset_vram_data got=%0h exp=0", vram_data); end
        checks++; if (cpu_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_cpu_busy got=%0b exp=0", cpu_busy); end
        checks++; if (fill_busy !== 1'b0) begin failures++; $display("[TB] FAIL reset_fill_busy got=%0b exp=0", fill_busy); end
        checks++; if (fill_done !== 1'b0) begin failures++; $display("[TB] FAIL reset_fill_done got=%0b exp=0", fill_done); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("[TB] FAIL reset_drop_cnt got=%0d exp=0", drop_cnt); end
        rst = 1'b1;
        step(2);
    endtask

    task automatic test_single_write();
        int acc;
        blank = 1'b1;
        step(1);
        clear_obs();
        cpu_write(9'd5, 16'hBEEF, acc);
        step(5);
        checks++; if (wr_q.size() != 1) begin failures++; $display("[TB] FAIL single_count got=%0d exp=1", wr_q.size()); end
        if (wr_q.size() >= 1) begin
            checks++; if (wr_q[0].addr !== 9'd5) begin failures++; $display("[TB] FAIL single_addr got=%0d exp=5", wr_q[0].addr); end
            checks++; if (wr_q[0].data !== 16'hBEEF) begin failures++; $display("[TB] FAIL single_data got=%0h exp=beef", wr_q[0].data); end
            checks++; if (wr_q[0].cyc != acc + 1) begin failures++; $display("[TB] FAIL single_latency got=%0d exp=%0d", wr_q[0].cyc, acc + 1); end
        end
        checks++; if (busy_seen !== 1'b0) begin failures++; $display("[TB] FAIL single_busy got=%0b exp=0", busy_seen); end
    endtask

    task automatic test_blank_hold();
        int acc;
        blank = 1'b0;
        step(1);
        clear_obs();
        cpu_write(9'd3, 16'h1111, acc);
        cpu_addr = 9'd4;
        cpu_data = 16'h2222;
        cpu_we   = 1'b1;
        for (int i = 0; i < 6; i++) begin
            #1;
            checks++; if (cpu_busy !== 1'b1) begin failures++; $display("[TB] FAIL hold_busy[%0d] got=%0b exp=1", i, cpu_busy); end
            @(posedge clk);
            #1;
        end
        checks++; if (wr_q.size() != 0) begin failures++; $display("[TB] FAIL hold_no_write got=%0d exp=0", wr_q.size()); end
        blank = 1'b1;
        #1;
        checks++; if (cpu_busy !== 1'b0) begin failures++; $display("[TB] FAIL hold_release_busy got=%0b exp=0", cpu_busy); end
        @(posedge clk);
        #1;
        cpu_we = 1'b0;
        step(5);
        checks++; if (wr_q.size() != 2) begin failures++; $display("[TB] FAIL hold_count got=%0d exp=2", wr_q.size()); end
        if (wr_q.size() >= 2) begin
            checks++; if (wr_q[0].addr !== 9'd3 || wr_q[0].data !== 16'h1111) begin failures++; $display("[TB] FAIL hold_first got=%0d/%0h exp=3/1111", wr_q[0].addr, wr_q[0].data); end
            checks++; if (wr_q[1].addr !== 9'd4 || wr_q[1].data !== 16'h2222) begin failures++; $display("[TB] FAIL hold_second got=%0d/%0h exp=4/2222", wr_q[1].addr, wr_q[1].data); end
            checks++; if (wr_q[1].cyc != wr_q[0].cyc + 1) begin failures++; $display("[TB] FAIL hold_back_to_back got=%0d exp=%0d", wr_q[1].cyc, wr_q[0].cyc + 1); end
        end
    endtask

    task automatic test_out_of_range();
        int acc;
        clear_obs();
        cpu_write(9'd48, 16'h1234, acc);
        cpu_write(9'd511, 16'h5678, acc);
        step(3);
        checks++; if (wr_q.size() != 0) begin failures++; $display("[TB] FAIL oor_no_write got=%0d exp=0", wr_q.size()); end
        checks++; if (drop_cnt !== 8'd2) begin failures++; $display("[TB] FAIL oor_drop_cnt got=%0d exp=2", drop_cnt); end
        for (int i = 0; i < 300; i++) begin
            cpu_write(9'($urandom_range(511, 48)), 16'($urandom), acc);
            if (i == 251) begin
                checks++; if (drop_cnt !== 8'd254) begin failures++; $display("[TB] FAIL oor_drop_254 got=%0d exp=254", drop_cnt); end
            end
        end
        step(2);
        checks++; if (drop_cnt !== 8'd255) begin failures++; $display("[TB] FAIL oor_saturate got=%0d exp=255", drop_cnt); end
        checks++; if (wr_q.size() != 0) begin failures++; $display("[TB] FAIL oor_no_write_sat got=%0d exp=0", wr_q.size()); end
    endtask

    task automatic test_fill(input logic [DATA_W-1:0] v, input string tag);
        int errs;
        blank = 1'b1;
        step(1);
        clear_obs();
        pulse_fill(v);
        wait_fill_done();
        checks++; if (wr_q.size() != DEPTH) begin failures++; $display("[TB] FAIL %s_count got=%0d exp=%0d", tag, wr_q.size(), DEPTH); end
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < DEPTH; i++) begin
            if (wr_q[i].addr !== 9'(i) || wr_q[i].data !== v || wr_q[i].cyc != wr_q[0].cyc + i) begin
                errs++;
                if (errs <= 4) $display("[TB] FAIL %s_cell[%0d] got=%0d/%0h@%0d exp=%0d/%0h@%0d", tag, i,
                                        wr_q[i].addr, wr_q[i].data, wr_q[i].cyc, i, v, wr_q[0].cyc + i);
            end
        end
        checks++; if (errs != 0) failures++;
        checks++; if (done_q.size() != 1) begin failures++; $display("[TB] FAIL %s_done_count got=%0d exp=1", tag, done_q.size()); end
        if (done_q.size() >= 1 && wr_q.size() >= 1) begin
            checks++; if (done_q[0] != wr_q[wr_q.size() - 1].cyc) begin failures++; $display("[TB] FAIL %s_done_time got=%0d exp=%0d", tag, done_q[0], wr_q[wr_q.size() - 1].cyc); end
            checks++; if (done_busy_q[0] !== 1'b0) begin failures++; $display("[TB] FAIL %s_busy_at_done got=%0b exp=0", tag, done_busy_q[0]); end
        end
        checks++; if (fill_busy !== 1'b0) begin failures++; $display("[TB] FAIL %s_busy_after got=%0b exp=0", tag, fill_busy); end
    endtask

    task automatic test_fill_collision();
        int   acc;
        int   errs;
        wr_t  exp_q[$];
        logic [DATA_W-1:0] mem [DEPTH];
        blank = 1'b1;
        step(1);
        clear_obs();
        pulse_fill(16'h00FF);
        step(9);
        cpu_write(9'd40, 16'hAAAA, acc);
        wait_fill_done();
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 10) exp_q.push_back('{9'd40, 16'hAAAA, 0});
            exp_q.push_back('{9'(i), 16'h00FF, 0});
        end
        checks++; if (wr_q.size() != DEPTH + 1) begin failures++; $display("[TB] FAIL coll_count got=%0d exp=%0d", wr_q.size(), DEPTH + 1); end
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data || wr_q[i].cyc != wr_q[0].cyc + i) begin
                errs++;
                if (errs <= 4) $display("[TB] FAIL coll_order[%0d] got=%0d/%0h exp=%0d/%0h", i,
                                        wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++; if (errs != 0) failures++;
        for (int i = 0; i < DEPTH; i++) mem[i] = 'x;
        foreach (wr_q[i]) if (wr_q[i].addr < DEPTH) mem[wr_q[i].addr] = wr_q[i].data;
        checks++; if (mem[40] !== 16'h00FF) begin failures++; $display("[TB] FAIL coll_cell40 got=%0h exp=00ff", mem[40]); end
        checks++; if (done_q.size() != 1) begin failures++; $display("[TB] FAIL coll_done_count got=%0d exp=1", done_q.size()); end
    endtask

    task automatic test_reset_mid_fill();
        int n_before;
        blank = 1'b1;
        step(1);
        clear_obs();
        pulse_fill(16'h5A5A);
        step(20);
        rst = 1'b0;
        #1;
        checks++; if (vram_we !== 1'b0) begin failures++; $display("[TB] FAIL midrst_vram_we got=%0b exp=0", vram_we); end
        checks++; if (fill_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_fill_busy got=%0b exp=0", fill_busy); end
        checks++; if (fill_done !== 1'b0) begin failures++; $display("[TB] FAIL midrst_fill_done got=%0b exp=0", fill_done); end
        checks++; if (drop_cnt !== 8'd0) begin failures++; $display("[TB] FAIL midrst_drop_cnt got=%0d exp=0", drop_cnt); end
        n_before = wr_q.size();
        checks++; if (n_before != 19) begin failures++; $display("[TB] FAIL midrst_partial got=%0d exp=19", n_before); end
        step(2);
        rst = 1'b1;
        step(6);
        checks++; if (wr_q.size() != n_before) begin failures++; $display("[TB] FAIL midrst_no_resume got=%0d exp=%0d", wr_q.size(), n_before); end
        checks++; if (done_q.size() != 0) begin failures++; $display("[TB] FAIL midrst_no_done got=%0d exp=0", done_q.size()); end
        checks++; if (fill_busy !== 1'b0) begin failures++; $display("[TB] FAIL midrst_idle got=%0b exp=0", fill_busy); end
        test_fill(16'($urandom), "restart");
    endtask

    task automatic test_random();
        wr_t exp_q[$];
        int  exp_drop;
        int  errs;
        bit  pending;
        bit  acc_last;
        exp_drop = 0;
        pending  = 0;
        acc_last = 0;
        step(1);
        clear_obs();
        for (int it = 0; it < 400; it++) begin
            if (pending && acc_last) begin
                if (cpu_addr < DEPTH) exp_q.push_back('{cpu_addr, cpu_data, 0});
                else exp_drop++;
                pending = 0;
            end
            blank = ($urandom_range(9, 0) < 6);
            if (!pending && $urandom_range(2, 0) != 0) begin
                pending  = 1;
                cpu_addr = ($urandom_range(9, 0) == 0) ? 9'($urandom_range(511, 48)) : 9'($urandom_range(47, 0));
                cpu_data = 16'($urandom);
            end
            cpu_we = pending;
            #1;
            acc_last = pending && (cpu_busy === 1'b0);
            @(posedge clk);
            #1;
        end
        if (pending && acc_last) begin
            if (cpu_addr < DEPTH) exp_q.push_back('{cpu_addr, cpu_data, 0});
            else exp_drop++;
        end
        cpu_we = 1'b0;
        blank  = 1'b1;
        step(5);
        checks++; if (wr_q.size() != exp_q.size()) begin failures++; $display("[TB] FAIL rand_count got=%0d exp=%0d", wr_q.size(), exp_q.size()); end
        errs = 0;
        for (int i = 0; i < wr_q.size() && i < exp_q.size(); i++) begin
            if (wr_q[i].addr !== exp_q[i].addr || wr_q[i].data !== exp_q[i].data) begin
                errs++;
                if (errs <= 4) $display("[TB] FAIL rand_write[%0d] got=%0d/%0h exp=%0d/%0h", i,
                                        wr_q[i].addr, wr_q[i].data, exp_q[i].addr, exp_q[i].data);
            end
        end
        checks++; if (errs != 0) failures++;
        checks++; if (drop_cnt !== 8'(exp_drop > 255 ? 255 : exp_drop)) begin failures++; $display("[TB] FAIL rand_drop got=%0d exp=%0d", drop_cnt, exp_drop); end
        checks++; if (gate_err != 0) begin failures++; $display("[TB] FAIL rand_blank_gate got=%0d exp=0", gate_err); end
    endtask

    initial begin
        test_reset();
        test_single_write();
        test_blank_hold();
        test_out_of_range();
        test_fill(16'h00FF, "fill");
        test_fill_collision();
        test_reset_mid_fill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vrams_write_scheduler.md
Name: vrams_write_scheduler

Overview:
- Sequences all writes into the 48-entry, 16-bit VRAMS sprite/tile array.
- Merges two write sources onto the array's single write port:
  - CPU store-path writes, through a one-entry holding buffer with stall.
  - A hardware fill engine that clears or paints the whole array.
- Can gate commits to display blanking so the VGA scanout never reads a half-updated frame.
- Sits between the CPU MMIO decode and the VRAMS storage write port. The read path is untouched.

Parameters:
- DEPTH, 48: number of valid VRAMS cells.
- ADDR_W, 9: address width, matching the VRAMS write address.
- DATA_W, 16: cell width.
- BLANK_SYNC, 1: 1 = commit writes only while blank=1; 0 = commit whenever possible.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset).
- cpu_we  in  1  CPU write request; accepted in a cycle where cpu_busy=0.
- cpu_addr  in  ADDR_W  CPU target cell.
- cpu_data  in  DATA_W  CPU write data.
- cpu_busy  out  1  holding buffer cannot accept; CPU must hold its request.
- fill_start  in  1  single-cycle pulse: start a fill of all DEPTH cells.
- fill_value  in  DATA_W  fill data; sampled on the fill_start cycle.
- fill_busy  out  1  fill engine active.
- fill_done  out  1  one-cycle pulse after the last fill write is issued.
- blank  in  1  display blanking interval from VGA timing (1 = not scanning).
- drop_cnt  out  8  saturating count of dropped out-of-range CPU writes.
- vram_we  out  1  registered write enable to VRAMS.
- vram_addr  out  ADDR_W  registered write address.
- vram_data  out  DATA_W  registered write data.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, buffer empty, FSM=IDLE, fill counter 0, drop_cnt 0.
  - A reset mid-fill abandons the fill; no fill_done is produced.
- Eligibility: ok = (BLANK_SYNC==0) | blank.
- Holding buffer (hb_valid, hb_addr, hb_data):
  - Accept when cpu_we & ~cpu_busy.
  - If cpu_addr >= DEPTH: not buffered; drop_cnt increments, saturating at 255.
  - cpu_busy = hb_valid & ~(ok). The buffer may issue and accept a new write in the same cycle.
- Issue arbitration, at most one write per cycle:
  - Priority 1: hb_valid & ok, issues the CPU buffer.
  - Priority 2: FSM=FILL & ok, issues fill cell fcnt.
  - Otherwise no issue.
- Output timing:
  - vram_we/addr/data are registered from the issue decision: issue in cycle N gives vram_we=1 during cycle N+1.
  - vram_addr and vram_data hold their last value when vram_we=0.
- Latency: CPU write accepted at edge E appears on vram_we in the cycle after edge E+1, if ok. Minimum of 2 edges from acceptance to the VRAMS array update.
- FSM:
  - IDLE:
    - fill_start: latch fill_value, fcnt=0, go to FILL.
  - FILL:
    - fill_busy=1.
    - On each fill issue: fcnt++.
    - On issuing fcnt==DEPTH-1: fill_done=1 the next cycle, go to IDLE.
    - fill_start while in FILL is ignored; fill_value is not re-latched.
  - fill_done is a registered pulse, high exactly one cycle.
- Simultaneous events:
  - CPU write and fill both pending: the CPU write wins and the fill stalls one cycle. Both writes land, CPU first.
  - A CPU write to a cell not yet filled is later overwritten by the fill. This is intended: the fill is an ordered clear.
- blank falling mid-fill: the fill pauses and resumes at the same fcnt when blank rises. No cell is skipped or repeated.
- Width rules: fcnt is 6 bits, zero-extended to ADDR_W on vram_addr. The out-of-range compare uses the full ADDR_W.

Decomposition:
- Shared package vrams_pkg:
  - VRAMS_DEPTH=48, VRAMS_ADDR_W=9, VRAMS_DATA_W=16.
  - FSM state enum {IDLE, FILL}.
  - The package is reused by the VRAMS storage and the VGA scanout.
- One natural sub-module, vrams_hold_buf: the one-entry buffer with its accept/issue/busy logic and the range check with drop counter.
- FSM and arbitration stay in the top module.

Test Plan:
- Reset, then a single CPU write with BLANK_SYNC=1, blank=1: addr=5, data=16'hBEEF.
  - Required: vram_we=1 with addr 5, data BEEF, exactly one cycle. cpu_busy stays 0.
- blank=0, CPU writes addr=3 data=16'h1111, then holds cpu_we for addr=4 data=16'h2222.
  - Required: cpu_busy=1 and no vram_we while blank=0.
  - Raise blank: addr 3 issues, then addr 4, in order, with no loss.
- Out-of-range: CPU writes addr 48, then addr 511.
  - Required: no vram_we, drop_cnt=2.
  - Repeat the drop 300 times: drop_cnt saturates at 255.
- Fill with blank=1: fill_start, fill_value=16'h00FF.
  - Required: 48 consecutive vram_we with addr 0..47, all data 00FF.
  - fill_done pulses one cycle after addr 47 issues. fill_busy falls with it.
- Fill collision: during a fill at fcnt=10, CPU writes addr=40 data=16'hAAAA.
  - Required: the CPU write issues first and cell 10 is delayed one cycle.
  - Total vram_we pulses = 49. Final cell 40 = 00FF.
- Reset mid-fill at fcnt=20: rst=0 for 2 cycles.
  - Required: vram_we, fill_busy and fill_done immediately 0; FSM=IDLE.
  - A following fill_start restarts at addr 0.
